// File: rtl/gsensor_pkg.sv
// Shared register map, state encoding and access helpers for the GSENSOR SPI responder model.
package gsensor_pkg;

  localparam logic [5:0] ADDR_DEVID  = 6'h00;
  localparam logic [5:0] ADDR_DATAX0 = 6'h32;
  localparam logic [5:0] ADDR_DATAX1 = 6'h33;
  localparam logic [5:0] ADDR_DATAY0 = 6'h34;
  localparam logic [5:0] ADDR_DATAY1 = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0 = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1 = 6'h37;

  localparam logic [7:0] DEVID_DEFAULT = 8'hE5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_t;

  function automatic logic is_read_only(input logic [5:0] i_addr);
    return (i_addr == ADDR_DEVID) || ((i_addr >= ADDR_DATAX0) && (i_addr <= ADDR_DATAZ1));
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Pin synchronizer with registered rise/fall pulses; pulse lags the pin by P_DEPTH+1 cycles.
module spi_edge_sync #(
  parameter int   P_DEPTH = 2,
  parameter logic P_INIT  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [P_DEPTH-1:0] r_sync;
  logic               r_last;
  logic               r_rise;
  logic               r_fall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {P_DEPTH{P_INIT}};
      r_last <= P_INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[P_DEPTH-2:0], i_pin};
      r_last <= r_sync[P_DEPTH-1];
      r_rise <= r_sync[P_DEPTH-1] & ~r_last;
      r_fall <= ~r_sync[P_DEPTH-1] & r_last;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 responder emulating the accelerometer register protocol over a 64-byte map.
// States: IDLE waits for CS_n low | CMD shifts the command byte | DATA moves data bytes.
module gsensor_spi_responder
  import gsensor_pkg::*;
#(
  parameter int         P_SCLK_SYNC = 2,
  parameter logic [7:0] P_DEVID     = DEVID_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_spi_sclk,
  input  logic        i_spi_cs_n,
  input  logic        i_spi_sdi,
  output logic        o_spi_sdo,
  output logic        o_spi_sdo_oe,
  input  logic        i_sample_valid,
  input  logic [15:0] i_accel_x,
  input  logic [15:0] i_accel_y,
  input  logic [15:0] i_accel_z,
  output logic        o_wr_valid,
  output logic [5:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_int1
);

  state_t r_state, w_state_nxt;
  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic [P_SCLK_SYNC-1:0] r_sdi_sync;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_shift_in;
  logic [7:0]  w_byte;
  logic        r_rw, r_mb;
  logic [5:0]  r_addr, w_addr_nxt;
  logic [7:0]  r_shift_out, w_rd_cmd, w_rd_nxt;
  logic        r_sdo;
  logic [7:0]  r_regs [64];
  logic [47:0] r_stage, r_sample;
  logic        r_pend, r_int1, r_wr_valid;
  logic [5:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        w_cmd_done, w_byte_done, w_apply, w_int_clr;

  spi_edge_sync #(.P_DEPTH(P_SCLK_SYNC), .P_INIT(1'b1)) u_sclk_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_spi_sclk),
    .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_edge_sync #(.P_DEPTH(P_SCLK_SYNC), .P_INIT(1'b1)) u_cs_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_spi_cs_n),
    .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  function automatic logic [7:0] reg_read(input logic [5:0] i_addr);
    case (i_addr)
      ADDR_DEVID:  return P_DEVID;
      ADDR_DATAX0: return r_sample[7:0];
      ADDR_DATAX1: return r_sample[15:8];
      ADDR_DATAY0: return r_sample[23:16];
      ADDR_DATAY1: return r_sample[31:24];
      ADDR_DATAZ0: return r_sample[39:32];
      ADDR_DATAZ1: return r_sample[47:40];
      default:     return r_regs[i_addr];
    endcase
  endfunction

  always_comb begin
    w_byte      = {r_shift_in, r_sdi_sync[P_SCLK_SYNC-1]};
    w_addr_nxt  = r_mb ? (r_addr + 6'd1) : r_addr;
    w_rd_cmd    = reg_read(w_byte[5:0]);
    w_rd_nxt    = reg_read(w_addr_nxt);
    w_cmd_done  = (r_state == ST_CMD) && w_sclk_rise && (r_bit_cnt == 3'd7) && !w_cs_rise;
    w_byte_done = (r_state == ST_DATA) && w_sclk_rise && (r_bit_cnt == 3'd7) && !w_cs_rise;
    w_int_clr   = w_byte_done && r_rw && (r_addr == ADDR_DATAX0);
    // Snapshot only moves while no transaction is in flight, so reads stay coherent.
    w_apply     = r_pend && (r_state == ST_IDLE);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
      ST_CMD:  if (w_cmd_done) w_state_nxt = ST_DATA;
      ST_DATA: w_state_nxt = ST_DATA;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_cs_rise) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sdi_sync  <= '0;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_rw        <= 1'b0;
      r_mb        <= 1'b0;
      r_addr      <= '0;
      r_shift_out <= '1;
      r_sdo       <= 1'b1;
      r_stage     <= '0;
      r_sample    <= '0;
      r_pend      <= 1'b0;
      r_int1      <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < 64; i++) r_regs[i] <= '0;
    end else begin
      r_sdi_sync <= {r_sdi_sync[P_SCLK_SYNC-2:0], i_spi_sdi};
      r_wr_valid <= 1'b0;

      if ((r_state == ST_IDLE) || w_cs_rise) begin
        r_bit_cnt <= '0;
      end else if (w_sclk_rise) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_shift_in <= w_byte[6:0];
      end

      if (w_cmd_done) begin
        r_rw        <= w_byte[7];
        r_mb        <= w_byte[6];
        r_addr      <= w_byte[5:0];
        r_shift_out <= w_rd_cmd;
      end

      if (w_byte_done) begin
        r_addr      <= w_addr_nxt;
        r_shift_out <= w_rd_nxt;
        if (!r_rw && !is_read_only(r_addr)) begin
          r_regs[r_addr] <= w_byte;
          r_wr_valid     <= 1'b1;
          r_wr_addr      <= r_addr;
          r_wr_data      <= w_byte;
        end
      end

      if ((r_state == ST_DATA) && r_rw && w_sclk_fall) begin
        r_sdo       <= r_shift_out[7];
        r_shift_out <= {r_shift_out[6:0], 1'b1};
      end

      if (i_sample_valid) r_stage <= {i_accel_z, i_accel_y, i_accel_x};
      if (i_sample_valid)   r_pend <= 1'b1;
      else if (w_apply)     r_pend <= 1'b0;
      if (w_apply) r_sample <= r_stage;

      if (w_apply)        r_int1 <= 1'b1;
      else if (w_int_clr) r_int1 <= 1'b0;
    end
  end

  assign o_spi_sdo_oe = (r_state == ST_DATA) && r_rw;
  assign o_spi_sdo    = o_spi_sdo_oe ? r_sdo : 1'b1;
  assign o_wr_valid   = r_wr_valid;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_int1       = r_int1;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Bench for gsensor_spi_responder: table of single-byte transactions plus burst/sample/abort sequences.
module tb_gsensor_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1, cs_n = 1'b1, sdi = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] ax = '0, ay = '0, az = '0;
  logic        sdo, sdo_oe, wr_valid, int1;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  int n_vec = 0;
  int n_err = 0;
  logic [13:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [13:0] mon_e;
  logic [7:0]  tx [8];

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] exp;
    bit         wr;
  } vec_t;
  vec_t tbl [11];

  always #10 clk = ~clk;

  gsensor_spi_responder dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_spi_sclk(sclk), .i_spi_cs_n(cs_n), .i_spi_sdi(sdi),
    .o_spi_sdo(sdo), .o_spi_sdo_oe(sdo_oe),
    .i_sample_valid(sample_valid), .i_accel_x(ax), .i_accel_y(ay), .i_accel_z(az),
    .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_int1(int1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every write pulse must match the next expected commit; a stretched pulse pops twice.
  always @(negedge clk) begin
    if (rst_n && wr_valid) begin
      if (exp_wr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_wr_q.pop_front();
        check("wr_beat", {18'd0, wr_addr, wr_data}, {18'd0, mon_e});
      end
    end
  end

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    ax = x; ay = y; az = z; sample_valid = 1'b1;
    clks(1);
    sample_valid = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [7:0] d [8], input int nbytes,
                      input int tail_bits, input bit chk_int);
    logic [7:0] rx, frame, e;
    int total, byte_i, bit_i;
    rx = '0;
    total = 8 * (1 + nbytes) + tail_bits;
    cs_n = 1'b0;
    clks(6);
    for (int b = 0; b < total; b++) begin
      byte_i = b / 8;
      bit_i  = 7 - (b % 8);
      frame  = (byte_i == 0) ? cmd : d[byte_i-1];
      sclk = 1'b0;
      sdi  = frame[bit_i];
      clks(8);
      if (byte_i > 0) begin
        rx[bit_i] = sdo;
        if (bit_i == 7) check("sdo_oe", {31'd0, sdo_oe}, {31'd0, cmd[7]});
      end
      sclk = 1'b1;
      clks(8);
      if (byte_i > 0 && bit_i == 0 && cmd[7]) begin
        if (exp_rd_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_unexpected: got %0h, expected no read data", rx);
        end else begin
          e = exp_rd_q.pop_front();
          check("rd_byte", {24'd0, rx}, {24'd0, e});
        end
        if (chk_int && byte_i == 1) check("int1_after_x0", {31'd0, int1}, 32'd0);
      end
    end
    clks(6);
    cs_n = 1'b1;
    clks(10);
  endtask

  initial begin
    clks(2000000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h80, 8'h00, 8'hE5, 1'b0};
    tbl[1]  = '{8'h2D, 8'h08, 8'h00, 1'b1};
    tbl[2]  = '{8'hAD, 8'h00, 8'h08, 1'b0};
    tbl[3]  = '{8'h20, 8'h5A, 8'h00, 1'b1};
    tbl[4]  = '{8'hA0, 8'h00, 8'h5A, 1'b0};
    tbl[5]  = '{8'h00, 8'h33, 8'h00, 1'b0};
    tbl[6]  = '{8'h80, 8'h00, 8'hE5, 1'b0};
    tbl[7]  = '{8'h33, 8'h77, 8'h00, 1'b0};
    tbl[8]  = '{8'hB3, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{8'h3F, 8'hC3, 8'h00, 1'b1};
    tbl[10] = '{8'hBF, 8'h00, 8'hC3, 1'b0};
    for (int i = 0; i < 8; i++) tx[i] = '0;

    clks(5);
    rst_n = 1'b1;
    clks(2);
    check("rst_sdo", {31'd0, sdo}, 32'd1);
    check("rst_sdo_oe", {31'd0, sdo_oe}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_int1", {31'd0, int1}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].cmd[7]) exp_rd_q.push_back(tbl[i].exp);
      else if (tbl[i].wr) exp_wr_q.push_back({tbl[i].cmd[5:0], tbl[i].data});
      tx[0] = tbl[i].data;
      xfer(tbl[i].cmd, tx, 1, 0, 1'b0);
    end

    pulse_sample(16'h1234, 16'hFF00, 16'h0001);
    clks(4);
    check("int1_set", {31'd0, int1}, 32'd1);
    exp_rd_q.push_back(8'h34); exp_rd_q.push_back(8'h12);
    exp_rd_q.push_back(8'h00); exp_rd_q.push_back(8'hFF);
    exp_rd_q.push_back(8'h01); exp_rd_q.push_back(8'h00);
    xfer(8'hF2, tx, 6, 0, 1'b1);
    check("int1_clear", {31'd0, int1}, 32'd0);

    exp_wr_q.push_back({6'h3E, 8'hAA});
    exp_wr_q.push_back({6'h3F, 8'hBB});
    tx[0] = 8'hAA; tx[1] = 8'hBB; tx[2] = 8'hCC;
    xfer(8'h7E, tx, 3, 0, 1'b0);
    check("last_wr_addr", {26'd0, wr_addr}, 32'h3F);
    check("last_wr_data", {24'd0, wr_data}, 32'hBB);
    exp_rd_q.push_back(8'hAA); exp_rd_q.push_back(8'hBB); exp_rd_q.push_back(8'hE5);
    xfer(8'hFE, tx, 3, 0, 1'b0);

    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    clks(4);
    check("int1_set_a", {31'd0, int1}, 32'd1);
    exp_rd_q.push_back(8'h11); exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22); exp_rd_q.push_back(8'h22);
    exp_rd_q.push_back(8'h33); exp_rd_q.push_back(8'h33);
    fork
      xfer(8'hF2, tx, 6, 0, 1'b1);
      begin
        clks(420);
        pulse_sample(16'hABCD, 16'h5566, 16'h7788);
      end
    join
    check("int1_set_b", {31'd0, int1}, 32'd1);
    exp_rd_q.push_back(8'hCD); exp_rd_q.push_back(8'hAB);
    exp_rd_q.push_back(8'h66); exp_rd_q.push_back(8'h55);
    exp_rd_q.push_back(8'h88); exp_rd_q.push_back(8'h77);
    xfer(8'hF2, tx, 6, 0, 1'b1);

    tx[0] = 8'hFF;
    xfer(8'h20, tx, 0, 5, 1'b0);
    exp_rd_q.push_back(8'h5A);
    xfer(8'hA0, tx, 1, 0, 1'b0);
    tx[0] = 8'h42;
    exp_wr_q.push_back({6'h21, 8'h42});
    xfer(8'h21, tx, 1, 0, 1'b0);
    exp_rd_q.push_back(8'h42);
    xfer(8'hA1, tx, 1, 0, 1'b0);

    clks(10);
    check("wr_queue_drained", exp_wr_q.size(), 32'd0);
    check("rd_queue_drained", exp_rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
